axistream_fifo: RTL

//  Parametrised AXI4-Stream FIFO with full backpressure, replacing the single-register stream stage.

---
 rtl/axistream_fifo_pkg.sv | 15 +
 rtl/axistream_fifo_mem.sv | 29 ++
 rtl/axistream_fifo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/axistream_fifo_pkg.sv
// Shared types and width helpers for the AXI4-Stream FIFO.
// A stored beat is packed as {last, data}.
package axistream_fifo_pkg;

    typedef enum logic {StIdle, StEscape} esc_state_e;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? unsigned'($clog2(depth)) : 1;
    endfunction

    function automatic int unsigned beat_width(input int unsigned data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/axistream_fifo_mem.sv
// Register-array storage for stream beats: one synchronous write port and
// one combinational read port that feeds the FIFO output register.
module axistream_fifo_mem
    import axistream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4,
    localparam int unsigned BeatW     = beat_width(DATA_WIDTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BeatW-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BeatW-1:0]  rdata
);

    logic [BeatW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axistream_fifo.sv
// AXI4-Stream FIFO with registered outputs, optional store-and-forward on
// tlast, and an escape path for packets larger than the storage.
module axistream_fifo
    import axistream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 16,
    parameter bit          PACKET_MODE = 1'b0,
    localparam int unsigned ADDR_W     = addr_width(DEPTH)
) (
    input  logic                  axi_clk,
    input  logic                  axi_resetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [ADDR_W:0]       fill_level,
    output logic                  pkt_overflow
);

    localparam int unsigned    BeatW     = beat_width(DATA_WIDTH);
    localparam logic [ADDR_W:0] FullLevel = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PtrOne    = (ADDR_W+1)'(1);

    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]  fill_q, fill_d, pkt_q, pkt_d;
    logic [BeatW-1:0] out_beat_q, out_beat_d, mem_rdata, in_beat;
    logic             out_valid_q, out_valid_d, tvalid_q, tvalid_d;
    logic             tready_q, tready_d, ovf_q, ovf_d;
    esc_state_e       state_q, state_d;
    logic             push, pop, push_last, pop_last, mem_empty, mem_we, out_free;

    assign in_beat   = {s_axis_tlast, s_axis_tdata};
    assign push      = s_axis_tvalid & tready_q;
    assign pop       = tvalid_q & m_axis_tready;
    assign push_last = push & s_axis_tlast;
    assign pop_last  = pop & out_beat_q[BeatW-1];
    assign mem_empty = (wr_ptr_q == rd_ptr_q);
    assign out_free  = ~out_valid_q | pop;

    axistream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk   (axi_clk),
        .we    (mem_we),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (in_beat),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        pkt_d       = pkt_q;
        out_beat_d  = out_beat_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        state_d     = state_q;
        mem_we      = 1'b0;

        // Output register refills from storage first; an empty FIFO bypasses storage.
        if (out_free) begin
            if (!mem_empty) begin
                out_beat_d  = mem_rdata;
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PtrOne;
                mem_we      = push;
            end else if (push) begin
                out_beat_d  = in_beat;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            mem_we = push;
        end
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end

        if (push && !pop) begin
            fill_d = fill_q + PtrOne;
        end else if (!push && pop) begin
            fill_d = fill_q - PtrOne;
        end

        if (push_last && !pop_last) begin
            pkt_d = pkt_q + PtrOne;
        end else if (!push_last && pop_last) begin
            pkt_d = pkt_q - PtrOne;
        end

        // Full of an unterminated packet: stream it out or the FIFO deadlocks.
        unique case (state_q)
            StIdle: begin
                if (PACKET_MODE && fill_q == FullLevel && pkt_q == '0) begin
                    state_d = StEscape;
                    ovf_d   = 1'b1;
                end
            end
            StEscape: begin
                if (pop_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        tvalid_d = out_valid_d & (~PACKET_MODE | (pkt_d != '0) | (state_d == StEscape));
        tready_d = (fill_d < FullLevel);
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            pkt_q       <= '0;
            out_beat_q  <= '0;
            out_valid_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tready_q    <= 1'b0;
            ovf_q       <= 1'b0;
            state_q     <= StIdle;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            pkt_q       <= pkt_d;
            out_beat_q  <= out_beat_d;
            out_valid_q <= out_valid_d;
            tvalid_q    <= tvalid_d;
            tready_q    <= tready_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = out_beat_q[BeatW-1];
    assign m_axis_tdata  = out_beat_q[DATA_WIDTH-1:0];
    assign fill_level    = fill_q;
    assign pkt_overflow  = ovf_q;

endmodule
